// File: rtl/arith_extend.sv
// rtl/arith_extend.sv - parallel per-lane sign/zero extender with optional output register
//
// Widens DEPTH independent lanes from IN_W to OUT_W bits. A single shared
// control input chooses sign extension (sign=1) or zero fill (sign=0) for
// every lane in the same cycle.
//
// Configuration macro: ARITH_EXTEND_REG_EN
//   defined     : out is registered, 1-cycle latency, async active-low reset
//                 clears all lanes immediately.
//   not defined : out follows the inputs combinationally; clock and reset
//                 are not used.
//
// Ports:
//   clock : rising-edge clock (registered build only)
//   reset : asynchronous active-low reset (registered build only)
//   in    : [IN_W-1:0]  x DEPTH input lanes
//   sign  : 1 = signed (replicate lane MSB), 0 = unsigned (zero fill)
//   out   : [OUT_W-1:0] x DEPTH extended lanes
module arith_extend #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IN_W-1:0]  in   [DEPTH],
    input  logic             sign,
    output logic [OUT_W-1:0] out  [DEPTH]
);

    // Narrowing would silently drop data and an empty lane set is meaningless.
    generate
        if (OUT_W < IN_W) begin : g_bad_width
            $error("arith_extend: OUT_W (%0d) must be >= IN_W (%0d)", OUT_W, IN_W);
        end
        if (DEPTH < 1) begin : g_bad_depth
            $error("arith_extend: DEPTH (%0d) must be >= 1", DEPTH);
        end
    endgenerate

    logic [OUT_W-1:0] ext [DEPTH];

    // Depending on build options some inputs have no load; gathering them
    // here keeps that intentional.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, clock, reset, sign};

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_lane
            // A zero-width replication is illegal, so equal widths get a
            // plain pass-through where sign has no effect.
            if (OUT_W == IN_W) begin : g_same
                assign ext[i] = in[i];
            end else begin : g_wide
                assign ext[i] = {{(OUT_W-IN_W){sign & in[i][IN_W-1]}}, in[i]};
            end

`ifdef ARITH_EXTEND_REG_EN
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    out[i] <= '0;
                end else begin
                    out[i] <= ext[i];
                end
            end
`else
            assign out[i] = ext[i];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_arith_extend.sv
// tb/tb_arith_extend.sv - self-checking bench for arith_extend (vector table, corner sequences, random vs model)
`timescale 1ns/1ps
module tb_arith_extend;

`ifdef ARITH_EXTEND_REG_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       sign;
    logic [3:0] tin   [2];
    logic [7:0] tout  [2];
    logic [3:0] tout2 [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #1 clock = ~clock;

    arith_extend #(.IN_W(4), .OUT_W(8), .DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .in    (tin),
        .sign  (sign),
        .out   (tout)
    );

    arith_extend #(.IN_W(4), .OUT_W(4), .DEPTH(2)) dut_eq (
        .clock (clock),
        .reset (reset),
        .in    (tin),
        .sign  (sign),
        .out   (tout2)
    );

    // Reference: a signed value with the top bit set is negative, so its wide
    // form is the value plus 2^out_w - 2^in_w; otherwise the value is unchanged.
    function automatic int model(int v, bit s, int in_w, int out_w);
        if (s && v >= (1 << (in_w - 1)))
            return v + (1 << out_w) - (1 << in_w);
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic s);
        tin[0] = a;
        tin[1] = b;
        sign   = s;
    endtask

    // Drive at a falling edge, then look at the result where it is defined:
    // after the next rising edge when registered, shortly after when not.
    task automatic apply(input string name, input logic [3:0] a, input logic [3:0] b,
                         input logic s, input logic [7:0] ea, input logic [7:0] eb);
        @(negedge clock);
        drive(a, b, s);
        if (REG) @(negedge clock);
        else #0.5;
        chk({name, "_l0"}, tout[0], ea);
        chk({name, "_l1"}, tout[1], eb);
        chk({name, "_eq0"}, {4'h0, tout2[0]}, {4'h0, a});
        chk({name, "_eq1"}, {4'h0, tout2[1]}, {4'h0, b});
    endtask

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    vec_t vecs [6];

    logic [7:0] pa, pb;
    logic [3:0] qa, qb;
    bit         have_prev;

    initial begin
        vecs[0] = '{"signed_a5",   4'hA, 4'h5, 1'b1, 8'hFA, 8'h05};
        vecs[1] = '{"zero_back",   4'h0, 4'h0, 1'b1, 8'h00, 8'h00};
        vecs[2] = '{"unsigned_af", 4'hA, 4'hF, 1'b0, 8'h0A, 8'h0F};
        vecs[3] = '{"signed_87",   4'h8, 4'h7, 1'b1, 8'hF8, 8'h07};
        vecs[4] = '{"signed_f0",   4'hF, 4'h0, 1'b1, 8'hFF, 8'h00};
        vecs[5] = '{"unsigned_8f", 4'h8, 4'hF, 1'b0, 8'h08, 8'h0F};

        // Reset held low with zero input.
        reset = 1'b0;
        drive(4'h0, 4'h0, 1'b1);
        #0.5;
        chk("rst_l0", tout[0], 8'h00);
        chk("rst_l1", tout[1], 8'h00);

        if (REG) begin
            // Nonzero inputs must not leak through while reset is low, across edges.
            drive(4'hA, 4'h8, 1'b1);
            repeat (2) @(negedge clock);
            chk("rst_hold_l0", tout[0], 8'h00);
            chk("rst_hold_l1", tout[1], 8'h00);
            chk("rst_hold_eq0", {4'h0, tout2[0]}, 8'h00);
            drive(4'h0, 4'h0, 1'b1);
        end

        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("post_rst_l0", tout[0], 8'h00);
        chk("post_rst_l1", tout[1], 8'h00);

        for (int i = 0; i < 6; i++)
            apply(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].ea, vecs[i].eb);

        // Equal-width instance ignores sign.
        apply("eq_signed", 4'hC, 4'h9, 1'b1, 8'hFC, 8'hF9);

        if (REG) begin
            // Mid-stream reset clears outputs before the next rising edge.
            apply("pre_rst", 4'hA, 4'h5, 1'b1, 8'hFA, 8'h05);
            #0.25;
            reset = 1'b0;
            #0.25;
            chk("midrst_l0", tout[0], 8'h00);
            chk("midrst_l1", tout[1], 8'h00);
            @(negedge clock);
            chk("midrst_hold_l0", tout[0], 8'h00);
            reset = 1'b1;
            #0.5;
            chk("midrst_rel_l0", tout[0], 8'h00);
            @(negedge clock);
            chk("midrst_first_l0", tout[0], 8'hFA);
            chk("midrst_first_l1", tout[1], 8'h05);

            // A sign change applies to the very sample it arrives with.
            @(negedge clock);
            drive(4'hB, 4'h3, 1'b0);
            @(negedge clock);
            drive(4'hB, 4'h3, 1'b1);
            chk("sgnchg_u_l0", tout[0], 8'h0B);
            @(negedge clock);
            chk("sgnchg_s_l0", tout[0], 8'hFB);
            chk("sgnchg_s_l1", tout[1], 8'h03);
        end

        // Random vectors, a new one every cycle.
        have_prev = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [3:0] a, b;
            logic       s;
            @(negedge clock);
            if (REG && have_prev) begin
                chk("rnd_l0", tout[0], pa);
                chk("rnd_l1", tout[1], pb);
                chk("rnd_eq0", {4'h0, tout2[0]}, {4'h0, qa});
                chk("rnd_eq1", {4'h0, tout2[1]}, {4'h0, qb});
            end
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            s = 1'($urandom_range(0, 1));
            drive(a, b, s);
            pa = 8'(model(int'(a), s, 4, 8));
            pb = 8'(model(int'(b), s, 4, 8));
            qa = a;
            qb = b;
            have_prev = 1'b1;
            if (!REG) begin
                #0.5;
                chk("rnd_l0", tout[0], pa);
                chk("rnd_l1", tout[1], pb);
                chk("rnd_eq0", {4'h0, tout2[0]}, {4'h0, qa});
                chk("rnd_eq1", {4'h0, tout2[1]}, {4'h0, qb});
            end
        end
        if (REG) begin
            @(negedge clock);
            chk("rnd_last_l0", tout[0], pa);
            chk("rnd_last_l1", tout[1], pb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
